// File: rtl/sw_debounce.sv
// sw_debounce: per-channel two-flop synchroniser plus tick-based stability filter for board switches.
// Define SW_DEBOUNCE_EDGE_EN to add registered sw_rise/sw_fall acceptance pulses.
module sw_debounce #(
    parameter int               WIDTH        = 8,
    parameter int               TICK_DIV     = 50000,
    parameter int               STABLE_TICKS = 20,
    parameter logic [WIDTH-1:0] INIT_VAL     = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] sw_raw,
`ifdef SW_DEBOUNCE_EDGE_EN
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
`endif
    output logic [WIDTH-1:0] sw_out
);

    localparam int CNT_W = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;
    localparam int TCK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(STABLE_TICKS - 1);
    localparam logic [TCK_W-1:0] TICK_LAST = TCK_W'(TICK_DIV - 1);

    logic [WIDTH-1:0] s1_p0;
    logic [WIDTH-1:0] s2_p1;
    logic [TCK_W-1:0] tick_cnt;
    logic             tick;
    logic [CNT_W-1:0] cnt [WIDTH];
    logic [WIDTH-1:0] accept;

    // Stage p0/p1: metastability synchroniser on the asynchronous pads
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_p0 <= INIT_VAL;
            s2_p1 <= INIT_VAL;
        end else begin
            s1_p0 <= sw_raw;
            s2_p1 <= s1_p0;
        end
    end

    // Free-running prescaler shared by every channel
    assign tick = (tick_cnt == TICK_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TCK_W'(1);
        end
    end

    always_comb begin
        accept = '0;
        for (int i = 0; i < WIDTH; i++) begin
            accept[i] = (s2_p1[i] != sw_out[i]) && tick && (cnt[i] == CNT_LAST);
        end
    end

    // Stage p2: stability window per channel; any return to the accepted level restarts it
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
            sw_out <= INIT_VAL;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (s2_p1[i] == sw_out[i]) begin
                    cnt[i] <= '0;
                end else if (tick) begin
                    cnt[i] <= accept[i] ? '0 : cnt[i] + CNT_W'(1);
                end
            end
            sw_out <= sw_out ^ accept;
        end
    end

`ifdef SW_DEBOUNCE_EDGE_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sw_rise <= '0;
            sw_fall <= '0;
        end else begin
            sw_rise <= accept & s2_p1;
            sw_fall <= accept & ~s2_p1;
        end
    end
`endif

endmodule

// File: tb/tb_sw_debounce.sv
// Scoreboard bench for sw_debounce (WIDTH=8, TICK_DIV=4, STABLE_TICKS=3, INIT_VAL=0).
module tb_sw_debounce;

    localparam int LAT_MIN = 11;
    localparam int LAT_MAX = 14;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] sw_raw = 8'hFF;
    logic [7:0] sw_out;
`ifdef SW_DEBOUNCE_EDGE_EN
    logic [7:0] sw_rise;
    logic [7:0] sw_fall;
`endif

    typedef struct {
        string      tag;
        logic [7:0] val;
        int         t0;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    logic [7:0] exp_state = 8'h00;

    sw_debounce #(
        .WIDTH(8), .TICK_DIV(4), .STABLE_TICKS(3), .INIT_VAL(8'h00)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .sw_raw(sw_raw),
`ifdef SW_DEBOUNCE_EDGE_EN
        .sw_rise(sw_rise),
        .sw_fall(sw_fall),
`endif
        .sw_out(sw_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int clamp_lat(input int l);
        if (l < LAT_MIN) return LAT_MIN;
        if (l > LAT_MAX) return LAT_MAX;
        return l;
    endfunction

    task automatic expect_out(input string tag, input logic [7:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        e.t0  = cyc;
        exp_q.push_back(e);
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            check({tag, "_timeout"}, exp_q.size(), 0);
            exp_q.delete();
        end
        repeat (6) @(negedge clk);
    endtask

    // Monitor: pops the scoreboard whenever sw_out moves
    always @(posedge clk) begin
        exp_t e;
        int   lat;
        #1;
        if (!reset_n) begin
            check("reset_out", sw_out, 8'h00);
`ifdef SW_DEBOUNCE_EDGE_EN
            check("reset_edges", {sw_rise, sw_fall}, 16'h0000);
`endif
        end else if (sw_out !== exp_state) begin
            if (exp_q.size() == 0) begin
                check("unexpected_change", sw_out, exp_state);
                exp_state = sw_out;
            end else begin
                e   = exp_q.pop_front();
                lat = cyc - e.t0;
                check({e.tag, "_val"}, sw_out, e.val);
                check({e.tag, "_lat"}, lat, clamp_lat(lat));
`ifdef SW_DEBOUNCE_EDGE_EN
                check({e.tag, "_rise"}, sw_rise, e.val & ~exp_state);
                check({e.tag, "_fall"}, sw_fall, ~e.val & exp_state);
`endif
                exp_state = e.val;
            end
        end else begin
`ifdef SW_DEBOUNCE_EDGE_EN
            if ((sw_rise | sw_fall) != 8'h00)
                check("edge_idle", {sw_rise, sw_fall}, 16'h0000);
`endif
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: all-high held through reset
        sw_raw  = 8'hFF;
        reset_n = 1'b0;
        repeat (5) @(negedge clk);
        reset_n = 1'b1;
        expect_out("t1_all", 8'hFF);
        drain("t1", 40);
        sw_raw = 8'h00;
        expect_out("t1_clear", 8'h00);
        drain("t1c", 40);

        // 2: short pulse must be filtered
        sw_raw[0] = 1'b1;
        repeat (5) @(negedge clk);
        sw_raw[0] = 1'b0;
        repeat (40) @(negedge clk);
        check("t2_hold", sw_out, 8'h00);

        // 3: single channel rise
        sw_raw[3] = 1'b1;
        expect_out("t3_rise", 8'h08);
        drain("t3", 40);

        // 4: two channels together
        sw_raw = sw_raw | 8'h42;
        expect_out("t4_pair", 8'h4A);
        drain("t4", 40);

        // 5: reset mid-window
        sw_raw[5] = 1'b1;
        repeat (9) @(negedge clk);
        reset_n   = 1'b0;
        exp_state = 8'h00;
        #1;
        check("t5_rst_now", sw_out, 8'h00);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        expect_out("t5_after", 8'h6A);
        drain("t5", 40);

        // 6: bouncing channel settles high
        for (int k = 0; k <= 12; k++) begin
            sw_raw[2] = (k % 2 == 0);
            if (k == 12) expect_out("t6_rise", 8'h6E);
            repeat (3) @(negedge clk);
        end
        drain("t6", 40);
        repeat (20) @(negedge clk);
        check("t6_final", sw_out, 8'h6E);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
